fakeram_sp_pipe: RTL
====================

# fakeram_sp_pipe

Parametrised single-port synchronous fake SRAM for fast-simulation and flow-test macros. Successor to the fixed 64-bit fakeram models: configurable width, depth and read latency, per-lane write mask, honoured chip enable, out-of-range detection, and a reset-driven clear sequencer. It is instantiated wherever a hard macro is stubbed out for synthesis, placement or simulation tests.

## Interface
- BITS, 64: data width.
- WORD_DEPTH, 16: number of words, 1 or more, not necessarily a power of two.
- ADDR_WIDTH, 5: address width; must satisfy 2**ADDR_WIDTH >= WORD_DEPTH.
- MASK_GRAN, 8: bits per write-mask lane; BITS % MASK_GRAN == 0. MASK_W = BITS/MASK_GRAN.
- READ_LATENCY, 1: read data latency in cycles, range 1..4.
- CLEAR_ON_RESET, 1: 1 means reset zeroes the array through the clear sequencer; 0 means array contents are untouched.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset. **One clock; reset is synchronous and active-low.**
- ce_in, input, 1: access enable.
- we_in, input, 1: write when ce_in=1.
- addr_in, input, ADDR_WIDTH: word address.
- wd_in, input, BITS: write data.
- wmask_in, input, MASK_W: lane write enable; 1 means write that lane.
- rd_out, output, BITS: read data.
- rd_valid_out, output, 1: rd_out carries new read data this cycle.
- oob_out, output, 1: the access accepted READ_LATENCY cycles earlier was out of range.
- busy_out, output, 1: clear in progress; all accesses are ignored.

## Operation
- An access is accepted on a rising edge with rst_n=1, busy_out=0 and ce_in=1.
- Write (we_in=1): lane k of mem[addr_in] takes wd_in lane k where wmask_in[k]=1. Other lanes are unchanged. A mask of all zeros is a no-op write.
- Read (we_in=0): returns mem[addr_in] after READ_LATENCY cycles with rd_valid_out=1.
- Write accesses do not produce rd_valid_out.
- A read in the cycle after a write to the same address returns the new data.
- Out of range (addr_in >= WORD_DEPTH):
  - writes are dropped;
  - reads return all-zero data with rd_valid_out=1;
  - oob_out=1, aligned with the slot where that access's response would appear. This holds for writes too.
- When no new valid read arrives, rd_out holds its last value. It is never forced to X.
- Clear sequencer states:
  - IDLE: normal operation.
  - CLEAR: writes zero to mem[ptr] and increments ptr each cycle. After ptr reaches WORD_DEPTH-1 it returns to IDLE.
  - Entry to CLEAR: any cycle with rst_n=0 and CLEAR_ON_RESET=1 forces CLEAR with ptr=0. The first zero-write happens on the first edge with rst_n=1.
  - busy_out=1 in CLEAR. With CLEAR_ON_RESET=0 the sequencer stays in IDLE.
- Reset asserted mid-clear restarts the clear from ptr=0.
- Reset asserted mid-read flushes the read pipeline; the in-flight response is lost.

## Timing
- Reset values:
  - rd_out=0, rd_valid_out=0, oob_out=0;
  - busy_out=1 if CLEAR_ON_RESET else 0;
  - read pipeline valid bits=0.
- Read accepted at edge N: rd_out, rd_valid_out and oob_out are valid after edge N+READ_LATENCY-1 and sampled at edge N+READ_LATENCY.
- Back-to-back reads are accepted every cycle, giving full throughput. The pipeline never stalls and has no backpressure.
- Clear duration: busy_out is high for exactly WORD_DEPTH cycles after rst_n deasserts. The first access accepted is in cycle WORD_DEPTH+1 after deassertion.
- ce_in is ignored while busy_out=1. There is no queuing, and the requester must wait.
- Write at edge N is visible to a read accepted at edge N+1.

## Structure
- Package fakeram_pkg holds:
  - the enum clr_state_e {CLR_IDLE, CLR_RUN};
  - localparam functions for MASK_W and counter width ($clog2(WORD_DEPTH+1));
  - the read pipeline stage struct {valid, oob, data}.
- Sub-module fakeram_rd_pipe implements a parametrised delay line of READ_LATENCY-1 stages with synchronous active-low flush. The first stage is the array read register in the top level.
- The top level contains the array, the mask-merge write, the range check and the clear FSM.

## Test plan
- BITS=64, MASK_GRAN=8, LAT=1, depth 16:
  - write 0x0123_4567_89AB_CDEF to addr 3 with mask 0xFF, then read addr 3 → 0x0123_4567_89AB_CDEF one cycle later, rd_valid_out=1;
  - write 0xFFFF…FF with mask 0x0F, then read → 0x0123_4567_FFFF_FFFF.
- LAT=3: reads of addr 0,1,2 on three consecutive cycles → three consecutive valid responses, the first 3 cycles after the first read, in order. A write in between produces no valid pulse.
- Range check, depth 17 and ADDR_WIDTH 5:
  - write to addr 20 → array unchanged;
  - read of addr 20 → rd_out=0, rd_valid_out=1, oob_out=1;
  - read of addr 16 → stored data, oob_out=0.
- CLEAR_ON_RESET=1, depth 16:
  - fill memory with nonzero data, pulse rst_n low for 1 cycle → busy_out high for exactly 16 cycles, and ce_in during busy has no effect;
  - all subsequent reads → 0.
- Reset mid-operation:
  - rst_n low during clear at ptr=7 → clear restarts and lasts the full 16 cycles;
  - rst_n low with a LAT=3 read in flight → no rd_valid_out, and rd_out=0.
- CLEAR_ON_RESET=0: reset preserves data written before reset, and busy_out stays 0.

Source files
------------

// File: rtl/fakeram_pkg.sv
// fakeram_pkg: shared types and sizing helpers for the fakeram_sp_pipe macro stub.
//   clr_state_e  - clear sequencer states
//   mask_w_f     - number of write-mask lanes for a data width / lane width
//   cnt_w_f      - clear pointer width, wide enough to hold WORD_DEPTH
//   idx_w_f      - array index width (at least 1 bit)
//   rd_tag_t     - the valid/oob flags of one read-pipeline stage; the data part
//                  is appended per module because its width is a parameter
package fakeram_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic valid;
    logic oob;
  } rd_tag_t;

  function automatic int mask_w_f(input int bits, input int gran);
    return bits / gran;
  endfunction

  function automatic int cnt_w_f(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int idx_w_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fakeram_rd_pipe.sv
// fakeram_rd_pipe: fixed-length delay line for read responses.
//   clk, rst_n          - clock and synchronous active-low flush
//   in_valid/oob/data   - response leaving the array read register
//   out_valid/oob/data  - the same response STAGES cycles later
// A flush zeroes every stage, data included, so a lost response never leaks.
module fakeram_rd_pipe
  import fakeram_pkg::*;
#(
  parameter int BITS   = 64,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_oob,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  output logic            out_oob,
  output logic [BITS-1:0] out_data
);

  typedef struct packed {
    rd_tag_t         tag;
    logic [BITS-1:0] data;
  } rd_stage_t;

  rd_stage_t stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0].tag.valid <= in_valid;
      stage_q[0].tag.oob   <= in_oob;
      stage_q[0].data      <= in_data;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_valid = stage_q[STAGES-1].tag.valid;
  assign out_oob   = stage_q[STAGES-1].tag.oob;
  assign out_data  = stage_q[STAGES-1].data;

endmodule

// File: rtl/fakeram_sp_pipe.sv
// fakeram_sp_pipe: single-port synchronous fake SRAM with lane write mask,
// range check, configurable read latency and a reset-driven clear sequencer.
//   clk, rst_n    - clock, synchronous active-low reset
//   ce_in, we_in  - access enable, write select
//   addr_in       - word address (may exceed WORD_DEPTH)
//   wd_in         - write data, wmask_in - per-lane write enable
//   rd_out        - read data (holds between reads)
//   rd_valid_out  - new read data this cycle
//   oob_out       - the access accepted READ_LATENCY cycles ago was out of range
//   busy_out      - clear in progress, accesses ignored
//
// Clear sequencer:
//   state    | meaning
//   CLR_IDLE | normal operation
//   CLR_RUN  | zeroing mem[ptr] each cycle, accesses ignored
module fakeram_sp_pipe
  import fakeram_pkg::*;
#(
  parameter  int BITS           = 64,
  parameter  int WORD_DEPTH     = 16,
  parameter  int ADDR_WIDTH     = 5,
  parameter  int MASK_GRAN      = 8,
  parameter  int READ_LATENCY   = 1,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int MASK_W         = mask_w_f(BITS, MASK_GRAN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [MASK_W-1:0]     wmask_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  output logic                  oob_out,
  output logic                  busy_out
);

  localparam int IDX_W = idx_w_f(WORD_DEPTH);
  localparam int CNT_W = cnt_w_f(WORD_DEPTH);

  logic [BITS-1:0]  mem [WORD_DEPTH];
  clr_state_e       state_q;
  logic [CNT_W-1:0] ptr_q;
  logic             busy_q;

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [BITS-1:0]  merged;

  logic             s0_valid_q;
  logic             s0_oob_q;
  logic [BITS-1:0]  s0_data_q;

  assign accept   = rst_n && !busy_q && ce_in;
  assign in_range = ({1'b0, addr_in} < (ADDR_WIDTH+1)'(WORD_DEPTH));
  assign idx      = addr_in[IDX_W-1:0];

  always_comb begin
    merged = mem[idx];
    for (int k = 0; k < MASK_W; k++) begin
      if (wmask_in[k]) merged[k*MASK_GRAN +: MASK_GRAN] = wd_in[k*MASK_GRAN +: MASK_GRAN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;
      busy_q  <= (CLEAR_ON_RESET != 0);
      ptr_q   <= '0;
    end else begin
      case (state_q)
        CLR_RUN: begin
          if (ptr_q == CNT_W'(WORD_DEPTH - 1)) begin
            state_q <= CLR_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= CLR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array contents are never reset directly; the clear sequencer owns zeroing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy_q) mem[ptr_q[IDX_W-1:0]] <= '0;
      else if (accept && we_in && in_range) mem[idx] <= merged;
    end
  end

  // Array read register: first latency stage. Data only moves on a real read
  // so rd_out holds across idle and write cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_oob_q   <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= accept && !we_in;
      s0_oob_q   <= accept && !in_range;
      if (accept && !we_in) s0_data_q <= in_range ? mem[idx] : '0;
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    fakeram_rd_pipe #(
      .BITS   (BITS),
      .STAGES (READ_LATENCY - 1)
    ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s0_valid_q),
      .in_oob    (s0_oob_q),
      .in_data   (s0_data_q),
      .out_valid (rd_valid_out),
      .out_oob   (oob_out),
      .out_data  (rd_out)
    );
  end else begin : g_direct
    assign rd_valid_out = s0_valid_q;
    assign oob_out      = s0_oob_q;
    assign rd_out       = s0_data_q;
  end

  assign busy_out = busy_q;

endmodule
